fifo_rd_drain: RTL and testbench

- Read-side consumer for the dual-clock FIFO (fifo2). Lives entirely in the read clock domain.
- Pops words through the FIFO's rinc/rempty/rdata port into a 2-entry output buffer, and presents them downstream on a valid/ready stream.
- Checks that the word sequence increments by 1, which is the pattern our write-side stimulus produces. Keeps word and error counters for bring-up and self-checking benches.

---
 rtl/fifo_rd_drain.sv | 151 +++++++++++++++
 tb/tb_fifo_rd_drain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Read-side consumer for the dual-clock FIFO. It lives entirely in the read
// clock domain. It pops words through the FIFO's fall-through port into a
// 2-entry output buffer and presents them on a valid/ready stream. It also
// checks that successive words increment by one.
//
// Ports:
//   rclk, rrst_n       read clock, asynchronous active-low reset
//   en                 level-sensitive drain enable
//   clr                synchronous clear of counters, error state and FSM
//   rempty, rdata      FIFO empty flag and head word (fall-through)
//   rinc               pop request to the FIFO
//   m_valid, m_data    downstream stream (buffer head)
//   m_ready            downstream accept
//   rd_count           words popped, wraps modulo 2^32
//   err_count          sequence mismatches, saturating
//   err_flag           sticky mismatch flag
//   busy               FSM is in RUN
module fifo_rd_drain #(
  parameter int DSIZE       = 32,
  parameter int CWIDTH      = 16,
  parameter int HALT_ON_ERR = 0
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              rempty,
  input  logic [DSIZE-1:0]  rdata,
  output logic              rinc,
  output logic              m_valid,
  output logic [DSIZE-1:0]  m_data,
  input  logic              m_ready,
  output logic [31:0]       rd_count,
  output logic [CWIDTH-1:0] err_count,
  output logic              err_flag,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [DSIZE-1:0]   r_buf0;
  logic [DSIZE-1:0]   r_buf1;
  logic [1:0]         r_bufCount;
  logic [DSIZE-1:0]   r_expected;
  logic               r_first;
  logic [31:0]        r_rdCount;
  logic [CWIDTH-1:0]  r_errCount;
  logic               r_errFlag;
  logic               w_rinc;
  logic               w_pop;
  logic               w_mismatch;

  // The pop request never looks at m_ready. The 2-entry buffer absorbs the
  // one-cycle gap between a pop and the downstream reaction. clr blocks the
  // pop so that a cleared cycle never consumes a word.
  assign w_rinc     = (r_state == RUN) && en && !rempty && (r_bufCount < 2'd2) && !clr;
  assign w_pop      = (r_bufCount != 2'd0) && m_ready;
  assign w_mismatch = w_rinc && r_first && (rdata != r_expected);

  assign rinc      = w_rinc;
  assign m_valid   = (r_bufCount != 2'd0);
  assign m_data    = r_buf0;
  assign rd_count  = r_rdCount;
  assign err_count = r_errCount;
  assign err_flag  = r_errFlag;
  assign busy      = (r_state == RUN);

  // State register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic. HALT is only left through clr, and clr wins over
  // everything else.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (en) w_nextState = RUN;
      RUN: begin
        if ((HALT_ON_ERR != 0) && w_mismatch) w_nextState = HALT;
        else if (!en)                         w_nextState = IDLE;
      end
      HALT:    w_nextState = HALT;
      default: w_nextState = IDLE;
    endcase
    if (clr) w_nextState = IDLE;
  end

  // Output buffer. r_buf0 is the head and r_buf1 is the tail. A push can
  // only happen with fewer than two entries, so push and pop together
  // happens only at count 1.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_bufCount <= 2'd0;
    end else begin
      case ({w_rinc, w_pop})
        2'b10: begin
          if (r_bufCount == 2'd0) r_buf0 <= rdata;
          else                    r_buf1 <= rdata;
          r_bufCount <= r_bufCount + 2'd1;
        end
        2'b01: begin
          r_buf0     <= r_buf1;
          r_bufCount <= r_bufCount - 2'd1;
        end
        2'b11: begin
          if (r_bufCount == 2'd1) begin
            r_buf0 <= rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Counters and the sequence checker. The expected value always follows
  // the received word, so a single bad word costs exactly one error. The
  // buffer is not touched by clr.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rdCount  <= 32'd0;
      r_errCount <= '0;
      r_errFlag  <= 1'b0;
      r_first    <= 1'b0;
      r_expected <= '0;
    end else if (clr) begin
      r_rdCount  <= 32'd0;
      r_errCount <= '0;
      r_errFlag  <= 1'b0;
      r_first    <= 1'b0;
    end else if (w_rinc) begin
      r_rdCount  <= r_rdCount + 32'd1;
      r_first    <= 1'b1;
      r_expected <= rdata + DSIZE'(1);
      if (w_mismatch) begin
        r_errFlag <= 1'b1;
        if (r_errCount != {CWIDTH{1'b1}}) r_errCount <= r_errCount + CWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain. Instance A uses HALT_ON_ERR=0 and
// instance B uses HALT_ON_ERR=1. Each instance is fed by its own simple
// fall-through FIFO model. Both instances share the control inputs.
module tb_fifo_rd_drain;

  logic        rclk = 1'b0;
  logic        rrstN = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        mReady = 1'b0;

  logic [31:0] memA [256];
  logic [7:0]  rdA = 8'd0;
  logic [7:0]  wrA = 8'd0;
  logic        remptyA, rincA, mValidA, errFlagA, busyA;
  logic [31:0] rdataA, mDataA, rdCountA;
  logic [15:0] errCountA;

  logic [31:0] memB [256];
  logic [7:0]  rdB = 8'd0;
  logic [7:0]  wrB = 8'd0;
  logic        remptyB, rincB, mValidB, errFlagB, busyB;
  logic [31:0] rdataB, mDataB, rdCountB;
  logic [15:0] errCountB;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  // FIFO models: the head word is visible while the model is non-empty, and
  // a word is consumed on each rising edge where rinc is 1.
  assign remptyA = (rdA == wrA);
  assign rdataA  = memA[rdA];
  assign remptyB = (rdB == wrB);
  assign rdataB  = memB[rdB];

  always @(posedge rclk) begin
    if (rincA) rdA <= rdA + 8'd1;
    if (rincB) rdB <= rdB + 8'd1;
  end

  fifo_rd_drain #(.DSIZE(32), .CWIDTH(16), .HALT_ON_ERR(0)) dutA (
    .rclk(rclk), .rrst_n(rrstN), .en(en), .clr(clr), .rempty(remptyA), .rdata(rdataA),
    .rinc(rincA), .m_valid(mValidA), .m_data(mDataA), .m_ready(mReady),
    .rd_count(rdCountA), .err_count(errCountA), .err_flag(errFlagA), .busy(busyA));

  fifo_rd_drain #(.DSIZE(32), .CWIDTH(16), .HALT_ON_ERR(1)) dutB (
    .rclk(rclk), .rrst_n(rrstN), .en(en), .clr(clr), .rempty(remptyB), .rdata(rdataB),
    .rinc(rincB), .m_valid(mValidB), .m_data(mDataB), .m_ready(mReady),
    .rd_count(rdCountB), .err_count(errCountB), .err_flag(errFlagB), .busy(busyB));

  task pushA(input logic [31:0] w);
    memA[wrA] = w;
    wrA = wrA + 8'd1;
  endtask

  task pushB(input logic [31:0] w);
    memB[wrB] = w;
    wrB = wrB + 8'd1;
  endtask

  // Puts both DUTs in reset and empties both FIFO models. Reset is released
  // on a falling edge.
  task doReset;
    rrstN = 1'b0; en = 1'b0; clr = 1'b0; mReady = 1'b0;
    wrA = rdA; wrB = rdB;
    repeat (2) @(negedge rclk);
    rrstN = 1'b1;
  endtask

  task test_reset;
    rrstN = 1'b0; en = 1'b0; clr = 1'b0; mReady = 1'b0;
    wrA = rdA; wrB = rdB;
    repeat (2) @(negedge rclk);
    checks++; if (rincA !== 1'b0) begin errors++; $display("[TB] FAIL reset_rinc: got %0d expected 0", rincA); end
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %0d expected 0", mValidA); end
    checks++; if (mDataA !== 32'd0) begin errors++; $display("[TB] FAIL reset_m_data: got %0h expected 0", mDataA); end
    checks++; if (rdCountA !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_count: got %0d expected 0", rdCountA); end
    checks++; if (errCountA !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d expected 0", errCountA); end
    checks++; if (errFlagA !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_flag: got %0d expected 0", errFlagA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0d expected 0", busyA); end
    rrstN = 1'b1;
    @(negedge rclk);
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_m_valid: got %0d expected 0", mValidA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_busy: got %0d expected 0", busyA); end
  endtask

  task test_stream;
    logic expRinc;
    doReset;
    for (int i = 1; i <= 8; i++) pushA(i);
    en = 1'b1; mReady = 1'b1;
    @(negedge rclk);
    checks++; if (rincA !== 1'b1) begin errors++; $display("[TB] FAIL stream_first_rinc: got %0d expected 1", rincA); end
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL stream_first_m_valid: got %0d expected 0", mValidA); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge rclk);
      expRinc = (k < 8);
      checks++; if (mValidA !== 1'b1) begin errors++; $display("[TB] FAIL stream_m_valid[%0d]: got %0d expected 1", k, mValidA); end
      checks++; if (mDataA !== 32'(k)) begin errors++; $display("[TB] FAIL stream_m_data[%0d]: got %0h expected %0h", k, mDataA, k); end
      checks++; if (rincA !== expRinc) begin errors++; $display("[TB] FAIL stream_rinc[%0d]: got %0d expected %0d", k, rincA, expRinc); end
    end
    @(negedge rclk);
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_m_valid: got %0d expected 0", mValidA); end
    checks++; if (rdCountA !== 32'd8) begin errors++; $display("[TB] FAIL stream_rd_count: got %0d expected 8", rdCountA); end
    checks++; if (errCountA !== 16'd0) begin errors++; $display("[TB] FAIL stream_err_count: got %0d expected 0", errCountA); end
    checks++; if (rincA !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_rinc: got %0d expected 0", rincA); end
  endtask

  task test_backpressure;
    logic [31:0] got [8];
    int n;
    doReset;
    for (int i = 1; i <= 5; i++) pushA(i);
    en = 1'b1; mReady = 1'b0;
    repeat (6) @(negedge rclk);
    checks++; if (rdCountA !== 32'd2) begin errors++; $display("[TB] FAIL bp_rd_count: got %0d expected 2", rdCountA); end
    checks++; if (rincA !== 1'b0) begin errors++; $display("[TB] FAIL bp_rinc: got %0d expected 0", rincA); end
    checks++; if (mValidA !== 1'b1) begin errors++; $display("[TB] FAIL bp_m_valid: got %0d expected 1", mValidA); end
    checks++; if (mDataA !== 32'd1) begin errors++; $display("[TB] FAIL bp_m_data: got %0h expected 1", mDataA); end
    @(negedge rclk);
    checks++; if (mDataA !== 32'd1) begin errors++; $display("[TB] FAIL bp_m_data_hold: got %0h expected 1", mDataA); end
    for (int i = 0; i < 8; i++) got[i] = 32'hDEAD_BEEF;
    n = 0;
    mReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (mValidA && n < 8) begin
        got[n] = mDataA;
        n++;
      end
      @(negedge rclk);
    end
    checks++; if (n !== 5) begin errors++; $display("[TB] FAIL bp_transfer_count: got %0d expected 5", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== 32'(i + 1)) begin errors++; $display("[TB] FAIL bp_order[%0d]: got %0h expected %0h", i, got[i], i + 1); end
    end
    checks++; if (rdCountA !== 32'd5) begin errors++; $display("[TB] FAIL bp_final_rd_count: got %0d expected 5", rdCountA); end
  endtask

  task test_sequence;
    doReset;
    pushA(32'd7); pushA(32'd8); pushA(32'd10); pushA(32'd11);
    en = 1'b1; mReady = 1'b1;
    repeat (3) @(negedge rclk);
    checks++; if (errCountA !== 16'd0) begin errors++; $display("[TB] FAIL seq_err_before_10: got %0d expected 0", errCountA); end
    @(negedge rclk);
    checks++; if (rdCountA !== 32'd3) begin errors++; $display("[TB] FAIL seq_rd_count_at_10: got %0d expected 3", rdCountA); end
    checks++; if (errCountA !== 16'd1) begin errors++; $display("[TB] FAIL seq_err_at_10: got %0d expected 1", errCountA); end
    checks++; if (errFlagA !== 1'b1) begin errors++; $display("[TB] FAIL seq_flag_at_10: got %0d expected 1", errFlagA); end
    @(negedge rclk);
    checks++; if (rdCountA !== 32'd4) begin errors++; $display("[TB] FAIL seq_rd_count_at_11: got %0d expected 4", rdCountA); end
    checks++; if (errCountA !== 16'd1) begin errors++; $display("[TB] FAIL seq_err_at_11: got %0d expected 1", errCountA); end
  endtask

  task test_wrap;
    doReset;
    pushA(32'hFFFF_FFFE); pushA(32'hFFFF_FFFF); pushA(32'h0); pushA(32'h1);
    en = 1'b1; mReady = 1'b1;
    repeat (6) @(negedge rclk);
    checks++; if (rdCountA !== 32'd4) begin errors++; $display("[TB] FAIL wrap_rd_count: got %0d expected 4", rdCountA); end
    checks++; if (errCountA !== 16'd0) begin errors++; $display("[TB] FAIL wrap_err_count: got %0d expected 0", errCountA); end
    checks++; if (errFlagA !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err_flag: got %0d expected 0", errFlagA); end
  endtask

  task test_halt;
    doReset;
    pushB(32'd3); pushB(32'd5); pushB(32'd6);
    en = 1'b1; mReady = 1'b0;
    repeat (3) @(negedge rclk);
    checks++; if (busyB !== 1'b0) begin errors++; $display("[TB] FAIL halt_busy: got %0d expected 0", busyB); end
    checks++; if (rincB !== 1'b0) begin errors++; $display("[TB] FAIL halt_rinc: got %0d expected 0", rincB); end
    checks++; if (remptyB !== 1'b0) begin errors++; $display("[TB] FAIL halt_rempty: got %0d expected 0", remptyB); end
    checks++; if (rdCountB !== 32'd2) begin errors++; $display("[TB] FAIL halt_rd_count: got %0d expected 2", rdCountB); end
    checks++; if (errCountB !== 16'd1) begin errors++; $display("[TB] FAIL halt_err_count: got %0d expected 1", errCountB); end
    checks++; if (errFlagB !== 1'b1) begin errors++; $display("[TB] FAIL halt_err_flag: got %0d expected 1", errFlagB); end
    checks++; if (mDataB !== 32'd3) begin errors++; $display("[TB] FAIL halt_m_data: got %0h expected 3", mDataB); end
    repeat (2) @(negedge rclk);
    checks++; if (rincB !== 1'b0) begin errors++; $display("[TB] FAIL halt_rinc_held: got %0d expected 0", rincB); end
    checks++; if (rdCountB !== 32'd2) begin errors++; $display("[TB] FAIL halt_rd_count_held: got %0d expected 2", rdCountB); end
    mReady = 1'b1;
    @(negedge rclk);
    checks++; if (mValidB !== 1'b1) begin errors++; $display("[TB] FAIL halt_drain_valid: got %0d expected 1", mValidB); end
    checks++; if (mDataB !== 32'd5) begin errors++; $display("[TB] FAIL halt_drain_data: got %0h expected 5", mDataB); end
    @(negedge rclk);
    checks++; if (mValidB !== 1'b0) begin errors++; $display("[TB] FAIL halt_drain_empty: got %0d expected 0", mValidB); end
    clr = 1'b1;
    @(negedge rclk);
    clr = 1'b0;
    checks++; if (rdCountB !== 32'd0) begin errors++; $display("[TB] FAIL halt_clr_rd_count: got %0d expected 0", rdCountB); end
    checks++; if (errCountB !== 16'd0) begin errors++; $display("[TB] FAIL halt_clr_err_count: got %0d expected 0", errCountB); end
    checks++; if (errFlagB !== 1'b0) begin errors++; $display("[TB] FAIL halt_clr_err_flag: got %0d expected 0", errFlagB); end
    checks++; if (busyB !== 1'b0) begin errors++; $display("[TB] FAIL halt_clr_busy: got %0d expected 0", busyB); end
    @(negedge rclk);
    checks++; if (rincB !== 1'b1) begin errors++; $display("[TB] FAIL halt_resume_rinc: got %0d expected 1", rincB); end
    @(negedge rclk);
    checks++; if (rdCountB !== 32'd1) begin errors++; $display("[TB] FAIL halt_resume_rd_count: got %0d expected 1", rdCountB); end
    checks++; if (errCountB !== 16'd0) begin errors++; $display("[TB] FAIL halt_resume_err: got %0d expected 0", errCountB); end
    checks++; if (mDataB !== 32'd6) begin errors++; $display("[TB] FAIL halt_resume_data: got %0h expected 6", mDataB); end
  endtask

  task test_en_and_reset;
    doReset;
    for (int i = 1; i <= 8; i++) pushA(i);
    en = 1'b1; mReady = 1'b1;
    repeat (3) @(negedge rclk);
    en = 1'b0;
    #1;
    checks++; if (rincA !== 1'b0) begin errors++; $display("[TB] FAIL en_drop_rinc: got %0d expected 0", rincA); end
    @(negedge rclk);
    checks++; if (rdCountA !== 32'd2) begin errors++; $display("[TB] FAIL en_drop_rd_count: got %0d expected 2", rdCountA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL en_drop_busy: got %0d expected 0", busyA); end
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL en_drop_m_valid: got %0d expected 0", mValidA); end
    en = 1'b1;
    @(negedge rclk);
    clr = 1'b1;
    #1;
    checks++; if (rincA !== 1'b0) begin errors++; $display("[TB] FAIL clr_rinc: got %0d expected 0", rincA); end
    @(negedge rclk);
    clr = 1'b0;
    checks++; if (rdCountA !== 32'd0) begin errors++; $display("[TB] FAIL clr_rd_count: got %0d expected 0", rdCountA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL clr_busy: got %0d expected 0", busyA); end
    repeat (2) @(negedge rclk);
    checks++; if (mValidA !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_m_valid: got %0d expected 1", mValidA); end
    rrstN = 1'b0;
    #1;
    checks++; if (rincA !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_rinc: got %0d expected 0", rincA); end
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_m_valid: got %0d expected 0", mValidA); end
    checks++; if (mDataA !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_m_data: got %0h expected 0", mDataA); end
    checks++; if (rdCountA !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_rd_count: got %0d expected 0", rdCountA); end
    @(negedge rclk);
    rrstN = 1'b1;
    #1;
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_m_valid: got %0d expected 0", mValidA); end
    @(negedge rclk);
    checks++; if (mValidA !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_m_valid: got %0d expected 0", mValidA); end
    checks++; if (rincA !== 1'b1) begin errors++; $display("[TB] FAIL rst_run_rinc: got %0d expected 1", rincA); end
    @(negedge rclk);
    checks++; if (mValidA !== 1'b1) begin errors++; $display("[TB] FAIL rst_pop_m_valid: got %0d expected 1", mValidA); end
    checks++; if (mDataA !== 32'd4) begin errors++; $display("[TB] FAIL rst_pop_m_data: got %0h expected 4", mDataA); end
    checks++; if (rdCountA !== 32'd1) begin errors++; $display("[TB] FAIL rst_pop_rd_count: got %0d expected 1", rdCountA); end
    checks++; if (errCountA !== 16'd0) begin errors++; $display("[TB] FAIL rst_pop_err_count: got %0d expected 0", errCountA); end
  endtask

  // Runs the scenarios in order and prints the summary line.
  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_sequence;
    test_wrap;
    test_halt;
    test_en_and_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stops a run that has stalled.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
